// File: rtl/sqrt_sum_pipe_pkg.sv
// Shared sizing helpers for the square-root-sum pipeline.
// The core, the adder tree and the bench all derive depths from these.
package sqrt_sum_pkg;

    function automatic int isqrt_stages(input int w);
        return w / 2;
    endfunction

    function automatic int tree_levels(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    function automatic int sqrt_sum_lat(input int w, input int n);
        return isqrt_stages(w) + tree_levels(n) + 1;
    endfunction

    // Number of partial sums alive at a given tree level.
    function automatic int level_count(input int n, input int l);
        return (n + (1 << l) - 1) >> l;
    endfunction

endpackage

// File: rtl/sqrt_sum_pipe_if.sv
// Argument/result bundle of the square-root-sum pipeline.
// There is no backpressure, so each direction carries only a valid bit and data.
interface sqrt_sum_pipe_if
    import sqrt_sum_pkg::*;
#(
    parameter int N_ARGS = 3,
    parameter int W      = 32
);
    localparam int RW = isqrt_stages(W) + tree_levels(N_ARGS);

    logic                         arg_vld;
    logic [N_ARGS-1:0][W-1:0]     args;
    logic                         res_vld;
    logic [RW-1:0]                res;

    modport master (output arg_vld, output args, input res_vld, input res);
    modport slave  (input arg_vld, input args, output res_vld, output res);
endinterface

// File: rtl/sqrt_sum_pipe_isqrt.sv
// Restoring digit-by-digit integer square root, one root bit per registered stage, MSB first.
// Data registers load only when their valid arrives; only the valid chain is reset.
module isqrt_pipe_param
    import sqrt_sum_pkg::*;
#(
    parameter int W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_vld,
    input  logic [W-1:0]     x,
    output logic             y_vld,
    output logic [W/2-1:0]   y
);
    localparam int H   = isqrt_stages(W);
    localparam int RMW = H + 2;

    typedef struct packed {
        logic [RMW-1:0] rem;
        logic [H-1:0]   root;
        logic [W-1:0]   x;
    } stage_t;

    stage_t         st_in [H];
    stage_t         st_q  [H];
    logic [H-1:0]   in_vld;
    logic [H-1:0]   vld_q;

    // The remainder entering a stage never exceeds H bits, so only its low half is shifted up.
    function automatic stage_t stage_step(input stage_t s);
        stage_t         n;
        logic [RMW-1:0] rem_t;
        logic [RMW-1:0] trial;
        rem_t  = {s.rem[H-1:0], s.x[W-1 -: 2]};
        trial  = {s.root, 2'b01};
        n.x    = s.x << 2;
        n.root = s.root << 1;
        if (rem_t >= trial) begin
            n.rem     = rem_t - trial;
            n.root[0] = 1'b1;
        end else begin
            n.rem = rem_t;
        end
        return n;
    endfunction

    always_comb begin
        st_in[0]  = '{rem: '0, root: '0, x: x};
        in_vld[0] = x_vld;
        for (int k = 1; k < H; k++) begin
            st_in[k]  = st_q[k-1];
            in_vld[k] = vld_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= in_vld;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < H; k++) begin
            if (in_vld[k]) begin
                st_q[k] <= stage_step(st_in[k]);
            end
        end
    end

    assign y_vld = vld_q[H-1];
    assign y     = st_q[H-1].root;

    logic unused_tail;
    assign unused_tail = ^{st_q[H-1].rem, st_q[H-1].x};

endmodule

// File: rtl/sqrt_sum_pipe.sv
// Sum of N_ARGS pipelined integer square roots through a registered pairwise adder tree.
// One argument set in and one result out per clock at a fixed latency.
module sqrt_sum_pipe
    import sqrt_sum_pkg::*;
#(
    parameter int N_ARGS = 3,
    parameter int W      = 32
) (
    input  logic          clk,
    input  logic          rst,
    sqrt_sum_pipe_if.slave bus
);
    localparam int H  = isqrt_stages(W);
    localparam int L  = tree_levels(N_ARGS);
    localparam int RW = H + L;

    if (W < 2 || (W % 2) != 0 || N_ARGS < 1) begin : g_bad_param
        $error("sqrt_sum_pipe: illegal parameters W=%0d N_ARGS=%0d", W, N_ARGS);
    end

    logic [H-1:0]      root_y [N_ARGS];
    logic [N_ARGS-1:0] root_vld;

    for (genvar i = 0; i < N_ARGS; i++) begin : g_sqrt
        isqrt_pipe_param #(.W(W)) u_isqrt (
            .clk   (clk),
            .rst   (rst),
            .x_vld (bus.arg_vld),
            .x     (bus.args[i]),
            .y_vld (root_vld[i]),
            .y     (root_y[i])
        );
    end

    // All root pipes run in lockstep, so one valid bit drives the whole tree.
    logic unused_root_vld;
    assign unused_root_vld = ^root_vld;

    for (genvar l = 0; l <= L; l++) begin : g_lvl
        localparam int CNT = level_count(N_ARGS, l);
        logic [H+l-1:0] sum [CNT];
        logic           vld;

        if (l == 0) begin : g_leaf
            assign vld = root_vld[0];
            for (genvar j = 0; j < CNT; j++) begin : g_in
                assign sum[j] = root_y[j];
            end
        end else begin : g_node
            localparam int PREV = level_count(N_ARGS, l - 1);

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld <= 1'b0;
                end else begin
                    vld <= g_lvl[l-1].vld;
                end
            end

            for (genvar j = 0; j < CNT; j++) begin : g_el
                if (2 * j + 1 < PREV) begin : g_add
                    always_ff @(posedge clk) begin
                        if (g_lvl[l-1].vld) begin
                            sum[j] <= {1'b0, g_lvl[l-1].sum[2*j]} + {1'b0, g_lvl[l-1].sum[2*j+1]};
                        end
                    end
                end else begin : g_pass
                    always_ff @(posedge clk) begin
                        if (g_lvl[l-1].vld) begin
                            sum[j] <= {1'b0, g_lvl[l-1].sum[2*j]};
                        end
                    end
                end
            end
        end
    end

    logic [RW-1:0] res_q;
    logic          res_vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_vld_q <= 1'b0;
            res_q     <= '0;
        end else begin
            res_vld_q <= g_lvl[L].vld;
            if (g_lvl[L].vld) begin
                res_q <= g_lvl[L].sum[0];
            end
        end
    end

    assign bus.res_vld = res_vld_q;
    assign bus.res     = res_q;

endmodule
